// File: rtl/conv_row_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_row_scheduler_if
// Description : Bus bundle between the row scheduler, the image ROM and the
//               convolution engine.
//               ROM side    : rom_en, rom_addr (out), rom_dout (in, 1-cycle lat.)
//               Engine side : win_o, win_valid, out_row (out), conv_done (in)
//               master = scheduler view, slave = ROM/engine view.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_row_scheduler_if #(
    parameter int W    = 24,
    parameter int PIX  = 8,
    parameter int NIMG = 16,
    parameter int K    = 3
);
    localparam int ADDR_W = $clog2(W * NIMG);
    localparam int ROW_W  = $clog2(W);

    logic                 rom_en;
    logic [ADDR_W-1:0]    rom_addr;
    logic [W*PIX-1:0]     rom_dout;
    logic [K*W*PIX-1:0]   win_o;
    logic                 win_valid;
    logic                 conv_done;
    logic [ROW_W-1:0]     out_row;

    modport master (
        output rom_en, rom_addr, win_o, win_valid, out_row,
        input  rom_dout, conv_done
    );

    modport slave (
        input  rom_en, rom_addr, win_o, win_valid, out_row,
        output rom_dout, conv_done
    );
endinterface
`default_nettype wire

// File: rtl/conv_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_row_scheduler
// Description : Streams one image frame from the image ROM into a K-row
//               sliding window for the convolution engine. One window is
//               presented per output row; the block advances on conv_done.
// Ports       : clk        - clock
//               rstn       - synchronous active-low reset
//               start      - raw button level (asynchronous, synchronised here)
//               img_sel    - image index, latched on the accepted start edge
//               busy       - frame in progress
//               frame_done - one-cycle pulse after the last window is consumed
//               bus        - ROM read port and engine window port (master)
// Revision    : 1.0 - initial release
// ============================================================================
module conv_row_scheduler #(
    parameter int W    = 24,
    parameter int PIX  = 8,
    parameter int NIMG = 16,
    parameter int K    = 3
) (
    input  wire logic                    clk,
    input  wire logic                    rstn,
    input  wire logic                    start,
    input  wire logic [$clog2(NIMG)-1:0] img_sel,
    output logic                         busy,
    output logic                         frame_done,
    conv_row_scheduler_if.master         bus
);
    localparam int ADDR_W   = $clog2(W * NIMG);
    localparam int ROW_W    = $clog2(W);
    localparam int SEL_W    = $clog2(NIMG);
    localparam int CNT_W    = $clog2(K + 1);
    localparam int ROW_BITS = W * PIX;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRIME   = 3'd1;
    localparam logic [2:0] S_PRESENT = 3'd2;
    localparam logic [2:0] S_FETCH   = 3'd3;
    localparam logic [2:0] S_SHIFT   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [ADDR_W-1:0] C_W_ADDR   = ADDR_W'(W);
    localparam logic [ADDR_W-1:0] C_K_ADDR   = ADDR_W'(K);
    localparam logic [ROW_W-1:0]  C_LAST_ROW = ROW_W'(W - K);
    localparam logic [CNT_W-1:0]  C_K_CNT    = CNT_W'(K);

    logic [2:0]            state_q, state_d;
    logic                  s1_q, s2_q;
    logic [SEL_W-1:0]      sel_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ROW_W-1:0]      out_row_q;
    logic [K*ROW_BITS-1:0] win_q;
    logic                  rd_q;
    logic [ADDR_W-1:0]     addr_hold_q;

    logic                  w_edge;
    logic                  w_last;
    logic                  w_rom_en;
    logic [ADDR_W-1:0]     w_row_idx;
    logic [ADDR_W-1:0]     w_addr;

    assign w_edge = s1_q & ~s2_q;
    assign w_last = (out_row_q == C_LAST_ROW);

    // PRIME reads rows 0..K-1 by counter; FETCH reads the row just past the window.
    assign w_row_idx = (state_q == S_PRIME) ? ADDR_W'(cnt_q) : (ADDR_W'(out_row_q) + C_K_ADDR);
    assign w_addr    = (ADDR_W'(sel_q) * C_W_ADDR) + w_row_idx;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (w_edge) state_d = S_PRIME;
            S_PRIME:   if (cnt_q == C_K_CNT) state_d = S_PRESENT;
            S_PRESENT: if (bus.conv_done) state_d = w_last ? S_DONE : S_FETCH;
            S_FETCH:   state_d = S_SHIFT;
            S_SHIFT:   state_d = S_PRESENT;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_rom_en      = ((state_q == S_PRIME) && (cnt_q < C_K_CNT)) || (state_q == S_FETCH);
        bus.rom_en    = w_rom_en;
        bus.rom_addr  = w_rom_en ? w_addr : addr_hold_q;
        bus.win_valid = (state_q == S_PRESENT);
        bus.win_o     = win_q;
        bus.out_row   = out_row_q;
        busy          = (state_q != S_IDLE);
        frame_done    = (state_q == S_DONE);
    end

    // Datapath: synchroniser, image latch, prime counter, window and row index
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            sel_q       <= '0;
            cnt_q       <= '0;
            out_row_q   <= '0;
            win_q       <= '0;
            rd_q        <= 1'b0;
            addr_hold_q <= '0;
        end else begin
            s1_q <= start;
            s2_q <= s1_q;
            // rd_q marks the cycle in which rom_dout carries the requested row
            rd_q <= w_rom_en;
            if (w_rom_en) begin
                addr_hold_q <= w_addr;
            end
            if ((state_q == S_IDLE) && w_edge) begin
                sel_q     <= img_sel;
                out_row_q <= '0;
            end
            if (state_q == S_PRIME) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
            // New rows always enter the top slot and push older rows down, so
            // priming and steady-state fetches share one shift path.
            if (rd_q) begin
                win_q <= {bus.rom_dout, win_q[K*ROW_BITS-1:ROW_BITS]};
            end
            if (rd_q && (state_q == S_SHIFT)) begin
                out_row_q <= out_row_q + ROW_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_row_scheduler
// Description : Self-checking bench for conv_row_scheduler. A ROM model
//               answers reads one cycle later; expected ROM addresses and
//               windows are queued when a frame is launched and compared as
//               the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_row_scheduler;
    localparam int W    = 24;
    localparam int PIX  = 8;
    localparam int NIMG = 16;
    localparam int K    = 3;
    localparam int NWIN = W - K + 1;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [3:0] img_sel;
    logic       busy;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;

    int                  exp_addr_q[$];
    logic [K*W*PIX-1:0]  exp_win_q[$];
    int                  exp_row_q[$];

    logic                wv_prev  = 1'b0;
    logic [K*W*PIX-1:0]  held_win = '0;

    conv_row_scheduler_if #(.W(W), .PIX(PIX), .NIMG(NIMG), .K(K)) bus ();

    conv_row_scheduler #(.W(W), .PIX(PIX), .NIMG(NIMG), .K(K)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .img_sel    (img_sel),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unique content per ROM row: pixel0/1 encode the address, others hashed.
    function automatic logic [W*PIX-1:0] row_data(input int a);
        logic [W*PIX-1:0] r;
        r = '0;
        r[0 +: PIX]   = 8'(a & 255);
        r[PIX +: PIX] = 8'((a >> 8) & 255);
        for (int p = 2; p < W; p++) r[p*PIX +: PIX] = 8'((a * 37 + p * 11) & 255);
        return r;
    endfunction

    function automatic logic [K*W*PIX-1:0] exp_win(input int s, input int r);
        logic [K*W*PIX-1:0] w;
        for (int i = 0; i < K; i++) w[i*W*PIX +: W*PIX] = row_data(s * W + r + i);
        return w;
    endfunction

    // ROM model: synchronous read, one-cycle latency
    always @(posedge clk) begin
        if (bus.rom_en === 1'b1) bus.rom_dout <= row_data(int'(bus.rom_addr));
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        int ea, er;
        logic [K*W*PIX-1:0] ew;
        if (bus.rom_en === 1'b1) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                failures++;
                $display("FAIL rom_addr unexpected read got=%0d want=none", bus.rom_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                if (int'(bus.rom_addr) !== ea) begin
                    failures++;
                    $display("FAIL rom_addr got=%0d want=%0d", bus.rom_addr, ea);
                end
            end
        end
        if (bus.win_valid === 1'b1 && wv_prev) begin
            checks++;
            if (bus.win_o !== held_win) begin
                failures++;
                $display("FAIL win_hold got=%h want=%h", bus.win_o, held_win);
            end
        end
        if (bus.win_valid === 1'b1 && !wv_prev) begin
            checks++;
            if (exp_win_q.size() == 0) begin
                failures++;
                $display("FAIL win_valid unexpected window out_row=%0d", bus.out_row);
            end else begin
                ew = exp_win_q.pop_front();
                er = exp_row_q.pop_front();
                if (bus.win_o !== ew) begin
                    failures++;
                    $display("FAIL win_o row=%0d got=%h want=%h", er, bus.win_o, ew);
                end
                checks++;
                if (int'(bus.out_row) !== er) begin
                    failures++;
                    $display("FAIL out_row got=%0d want=%0d", bus.out_row, er);
                end
            end
            held_win = bus.win_o;
        end
        if (frame_done === 1'b1) fd_cnt++;
        wv_prev = (bus.win_valid === 1'b1);
    end

    task automatic flush_expect();
        exp_addr_q.delete();
        exp_win_q.delete();
        exp_row_q.delete();
    endtask

    // Launch one frame and act as the conv engine.
    //   d           : cycles from win_valid rise to conv_done
    //   glitch      : pulse conv_done in PRIME and in every FETCH
    //   restart_row : press start again (img_sel=7) while this window is shown
    //   abort_row   : pull rstn low for one cycle when this window appears
    task automatic run_frame(input int sel, input int d, input bit glitch,
                             input int restart_row, input int abort_row);
        int wins;
        int t;
        int nd;
        wins = 0;
        fd_cnt = 0;
        for (int r = 0; r < NWIN; r++) begin
            exp_win_q.push_back(exp_win(sel, r));
            exp_row_q.push_back(r);
        end
        for (int a = 0; a < W; a++) exp_addr_q.push_back(sel * W + a);
        @(negedge clk);
        img_sel = 4'(sel);
        start   = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        if (glitch) begin
            bus.conv_done = 1'b1;
            @(negedge clk);
            bus.conv_done = 1'b0;
        end
        for (int r = 0; r < NWIN; r++) begin
            t = 0;
            while (bus.win_valid !== 1'b1 && t < 60) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (bus.win_valid !== 1'b1) begin
                failures++;
                $display("FAIL win_valid_timeout row=%0d got=0 want=1", r);
                flush_expect();
                return;
            end
            if (r > 0) begin
                checks++;
                if (t !== 1) begin
                    failures++;
                    $display("FAIL win_valid_c3 row=%0d got_delay=%0d want=1", r, t);
                end
            end
            wins++;
            if (r == abort_row) begin
                rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
                checks++;
                if ({bus.rom_en, bus.win_valid, busy, frame_done} !== 4'b0000 ||
                    bus.rom_addr !== '0 || bus.out_row !== '0 || bus.win_o !== '0) begin
                    failures++;
                    $display("FAIL abort_outputs got en=%b wv=%b busy=%b fd=%b addr=%0d row=%0d want all 0",
                             bus.rom_en, bus.win_valid, busy, frame_done, bus.rom_addr, bus.out_row);
                end
                flush_expect();
                repeat (4) @(negedge clk);
                checks++;
                if (fd_cnt !== 0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_no_done got fd=%0d busy=%b want fd=0 busy=0", fd_cnt, busy);
                end
                return;
            end
            nd = d;
            if (r == restart_row) begin
                img_sel = 4'd7;
                start   = 1'b1;
                nd      = 4;
            end
            for (int j = 0; j < nd; j++) begin
                @(negedge clk);
                if (j == 2) start = 1'b0;
            end
            bus.conv_done = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.win_valid !== 1'b0 || bus.rom_en !== (r != NWIN - 1) ||
                frame_done !== (r == NWIN - 1)) begin
                failures++;
                $display("FAIL c1_state row=%0d got wv=%b en=%b fd=%b want wv=0 en=%b fd=%b",
                         r, bus.win_valid, bus.rom_en, frame_done, r != NWIN - 1, r == NWIN - 1);
            end
            if (!glitch) bus.conv_done = 1'b0;
            @(negedge clk);
            bus.conv_done = 1'b0;
            start = 1'b0;
        end
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL end_busy got busy=%b fd=%b want 0 0", busy, frame_done);
        end
        checks++;
        if (wins !== NWIN || fd_cnt !== 1) begin
            failures++;
            $display("FAIL frame_count got wins=%0d fd=%0d want wins=%0d fd=1", wins, fd_cnt, NWIN);
        end
        checks++;
        if (exp_addr_q.size() !== 0 || exp_win_q.size() !== 0) begin
            failures++;
            $display("FAIL leftover got addr=%0d win=%0d want 0 0", exp_addr_q.size(), exp_win_q.size());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (int'(bus.out_row) !== NWIN - 1 || bus.win_o !== exp_win(sel, NWIN - 1) || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got row=%0d busy=%b want row=%0d busy=0", bus.out_row, busy, NWIN - 1);
        end
        flush_expect();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b0;
        img_sel = 4'd0;
        bus.conv_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rom_en !== 1'b0 || bus.rom_addr !== '0) begin
            failures++;
            $display("FAIL reset_rom got en=%b addr=%0d want 0 0", bus.rom_en, bus.rom_addr);
        end
        checks++;
        if (bus.win_o !== '0 || bus.win_valid !== 1'b0 || bus.out_row !== '0) begin
            failures++;
            $display("FAIL reset_win got wv=%b row=%0d want 0 0", bus.win_valid, bus.out_row);
        end
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got busy=%b fd=%b want 0 0", busy, frame_done);
        end
        rstn = 1'b1;
        @(negedge clk);
        bus.conv_done = 1'b1;
        @(negedge clk);
        bus.conv_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.win_valid !== 1'b0 || bus.rom_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_conv_done got busy=%b wv=%b en=%b want 0 0 0", busy, bus.win_valid, bus.rom_en);
        end
    endtask

    task automatic test_frame_sel0();          run_frame(0, 2, 1'b0, -1, -1); endtask
    task automatic test_frame_sel15();         run_frame(15, 1, 1'b0, -1, -1); endtask
    task automatic test_conv_done_ignored();   run_frame(4, 2, 1'b1, -1, -1); endtask
    task automatic test_restart_ignored();     run_frame(2, 2, 1'b0, 5, -1); endtask
    task automatic test_reset_mid_frame();
        run_frame(9, 2, 1'b0, -1, 10);
        run_frame(9, 2, 1'b0, -1, -1);
    endtask
    task automatic test_back_to_back();        run_frame(6, 0, 1'b0, -1, -1); endtask

    initial begin
        bus.conv_done = 1'b0;
        test_reset();
        test_frame_sel0();
        test_frame_sel15();
        test_conv_done_ignored();
        test_restart_ignored();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/conv_row_scheduler.md
Name: conv_row_scheduler

Overview:
- Sequences one image frame from the image ROM into a 3-row sliding window for the convolution engine.
- Triggered by a start button and an image select; one window is presented per output row, and the block advances on the engine's conv_done pulse.
- Sits between the image ROM (synchronous read, 1-cycle latency) and the conv engine, replacing ad-hoc row streaming with an explicit FSM.

Parameters:
W, 24, pixels per row and rows per image
PIX, 8, bits per pixel
NIMG, 16, images stored in ROM
K, 3, window height in rows

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
start  in  1  raw button level, asynchronous to clk
img_sel  in  4  image index; latched on the accepted start edge
rom_en  out  1  ROM read enable
rom_addr  out  clogb2(W*NIMG-1)  ROM row address = sel*W + row
rom_dout  in  W*PIX  ROM row data, valid the cycle after rom_en
win_o  out  K*W*PIX  window; bits [W*PIX-1:0] hold the oldest row, the top slice holds the newest row
win_valid  out  1  window stable and ready for the conv engine
conv_done  in  1  single-cycle pulse from the engine: window consumed
out_row  out  clogb2(W-1)  index of the oldest row in the window (output row number)
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last window is consumed

Behaviour:
- Reset: every output is 0 (rom_en, rom_addr, win_o, win_valid, out_row, busy, frame_done); the FSM goes to IDLE; the start synchronizer flops clear. Reset mid-frame aborts immediately, with no frame_done.
- Start detect: start passes through 2 flops (s1, s2). The edge is s1 & ~s2, evaluated in the registered domain. The edge is accepted only in IDLE; in any other state it is ignored.
- On an accepted edge: latch sel = img_sel, set busy = 1, out_row = 0, and go to PRIME.
- PRIME: rom_en = 1 for K consecutive cycles T..T+K-1, with addresses sel*W+0 .. sel*W+K-1.
  - rom_dout is captured at the end of cycles T+1..T+K into window slots 0..K-1.
  - The FSM enters PRESENT at T+K+1.
- PRESENT: win_valid = 1, and win_o is held constant.
  - conv_done is sampled only in this state; it is accepted even in the first cycle of win_valid.
  - On conv_done (cycle C), win_valid = 0 from C+1.
  - If out_row == W-K, go to DONE; otherwise go to FETCH.
- FETCH (cycle C+1): rom_en = 1, rom_addr = sel*W + out_row + K.
  - At the end of C+2 the window shifts down one slot: slot0 is dropped and the new row enters slot K-1.
  - out_row increments at the same edge.
  - The FSM enters PRESENT with win_valid = 1 at C+3.
- DONE (cycle C+1): frame_done = 1 for exactly one cycle; busy = 0 from C+2; the FSM returns to IDLE.
  - win_o and out_row keep their last values until the next start.
- Frame size: windows per frame = W-K+1 (22 by default), so there are exactly W ROM reads per frame. No address reaches (sel+1)*W.
- Arithmetic: rom_addr is computed as sel*W + row at full address width, with no wrap. With defaults the maximum address is 15*24+23 = 383.
- rom_en is 0 in IDLE, PRESENT and DONE. rom_addr holds its last value when rom_en = 0.
- conv_done is ignored in IDLE, PRIME, FETCH and DONE, with no state change. Changes to img_sel during a frame have no effect.
- A start edge in the DONE cycle is ignored. An edge arriving in the first IDLE cycle after DONE is accepted.

Test Plan:
- img_sel=0, start pulse, conv_done 2 cycles after each win_valid rise -> rom_addr sequence 0..23, 22 win_valid assertions, out_row 0..21, one frame_done, busy low afterwards.
- img_sel=15 -> first address 360, last address 383. The first win_o equals rows 360/361/362 at slots 0/1/2.
- conv_done pulsed during PRIME and during FETCH -> no state change, no extra out_row increment, window contents unchanged.
- Second start edge at out_row=5 with img_sel changed to 7 -> ignored; the frame completes on the original image.
- rstn low for 1 cycle at out_row=10 -> all outputs 0 the next cycle, no frame_done. A new start then begins again at address sel*W.
- conv_done in the same cycle win_valid first rises -> accepted; FETCH follows the next cycle. win_valid timing is checked at C+1 = 0 and C+3 = 1.
